// File: rtl/tone_pkg.sv
// Shared tone protocol constants: note divider table, classification thresholds,
// octave window and decoder state encoding. Also used by the tone generator.
package tone_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_MEASURE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  typedef struct packed {
    logic [2:0] octave;
    logic [3:0] note;
  } tone_code_t;

  // div+1 per note, A first; the generator half-period is DIV_TAB[n] * (256 >> octave)
  localparam int unsigned DIV_TAB [12] = '{512, 483, 456, 431, 406, 384,
                                           362, 342, 323, 304, 287, 271};

  // Midpoints between adjacent octave-0-scaled table entries, descending
  localparam int unsigned THR [11] = '{127360, 120192, 113536, 107136, 101120, 95488,
                                       90112, 85120, 80256, 75648, 71424};

  localparam int unsigned WIN_LO = 67456;
  localparam int unsigned WIN_HI = 134912;

  function automatic int unsigned gen_half(input logic [2:0] oct, input logic [3:0] nt);
    return DIV_TAB[nt] * (32'd256 >> oct);
  endfunction

endpackage

// File: rtl/tone_classifier.sv
// Combinational half-period classifier: scales h into the octave-0 window,
// then picks the note by counting thresholds above the scaled value.
module tone_classifier
  import tone_pkg::*;
#(
  parameter int CNT_W    = 18,
  parameter int MIN_HALF = 2048
) (
  input  logic [CNT_W-1:0] h,
  output logic             reject,
  output logic [2:0]       octave,
  output logic [3:0]       note
);

  logic [31:0] h_ext;
  logic [31:0] v;
  logic        found;

  assign h_ext = 32'(h);

  always_comb begin
    found  = 1'b0;
    octave = 3'd0;
    v      = 32'd0;
    note   = 4'd0;
    // Smallest shift that lifts h into the window wins
    for (int o = 0; o <= 5; o++) begin
      if (!found && ((h_ext << o) >= WIN_LO)) begin
        found  = 1'b1;
        octave = 3'(o);
        v      = h_ext << o;
      end
    end
    for (int i = 0; i < 11; i++) begin
      if (THR[i] > v) note = note + 4'd1;
    end
    reject = !found || (h_ext < 32'(MIN_HALF)) || (h_ext >= WIN_HI);
  end

endmodule

// File: rtl/tone_decoder.sv
// Recovers the fullnote code from a speaker-line square wave by timing its
// half-periods and requiring LOCK_COUNT matching classifications.
module tone_decoder
  import tone_pkg::*;
#(
  parameter int CNT_W      = 18,
  parameter int TIMEOUT    = 150000,
  parameter int MIN_HALF   = 2048,
  parameter int LOCK_COUNT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tone_in,
  output logic [5:0]       fullnote,
  output logic [2:0]       octave,
  output logic [3:0]       note,
  output logic             note_valid,
  output logic             new_note,
  output logic [CNT_W-1:0] half_period
);

  logic             sync1, sync2, sync2_d, edge_q;
  logic [CNT_W-1:0] cnt, h_q;
  logic             cap_v;
  logic [1:0]       state;
  tone_code_t       cand, c_code;
  logic [3:0]       match, m_next;
  logic             c_rej, same, hit;
  logic [5:0]       c_full;

  tone_classifier #(.CNT_W(CNT_W), .MIN_HALF(MIN_HALF)) u_cls (
    .h      (h_q),
    .reject (c_rej),
    .octave (c_code.octave),
    .note   (c_code.note)
  );

  always_comb begin
    same   = (c_code == cand);
    m_next = 4'd1;
    if (same) m_next = (match == 4'hf) ? match : match + 4'd1;
    hit    = cap_v && !c_rej && (m_next == 4'(LOCK_COUNT));
    c_full = 6'(c_code.octave) * 6'd12 + 6'(c_code.note);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      sync2_d     <= 1'b0;
      edge_q      <= 1'b0;
      cnt         <= '0;
      h_q         <= '0;
      cap_v       <= 1'b0;
      state       <= ST_IDLE;
      cand        <= '0;
      match       <= 4'd0;
      fullnote    <= 6'd0;
      octave      <= 3'd0;
      note        <= 4'd0;
      note_valid  <= 1'b0;
      new_note    <= 1'b0;
      half_period <= '0;
    end else begin
      sync1    <= tone_in;
      sync2    <= sync1;
      sync2_d  <= sync2;
      edge_q   <= sync2 ^ sync2_d;
      new_note <= 1'b0;

      if (cap_v) begin
        if (c_rej) begin
          match <= 4'd0;
        end else begin
          half_period <= h_q;
          match       <= m_next;
          cand        <= c_code;
          if (hit) begin
            state      <= ST_LOCKED;
            fullnote   <= c_full;
            octave     <= c_code.octave;
            note       <= c_code.note;
            note_valid <= 1'b1;
            // Re-confirming the code already shown is not a change
            new_note   <= (state != ST_LOCKED) || (c_code.octave != octave) || (c_code.note != note);
          end
        end
      end

      if (edge_q) begin
        cnt   <= CNT_W'(1);
        h_q   <= cnt;
        // The edge that leaves IDLE closes no meaningful interval
        cap_v <= (state != ST_IDLE);
        if (state == ST_IDLE) state <= ST_MEASURE;
      end else begin
        cap_v <= 1'b0;
        if (cnt != '1) cnt <= cnt + CNT_W'(1);
        if (cnt == CNT_W'(TIMEOUT)) begin
          state      <= ST_IDLE;
          cand       <= '0;
          match      <= 4'd0;
          fullnote   <= 6'd0;
          octave     <= 3'd0;
          note       <= 4'd0;
          note_valid <= 1'b0;
          new_note   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_tone_decoder.sv
// Directed bench for tone_decoder: lock, code change, glitch, silence timeout,
// range edges and asynchronous reset while locked.
module tb_tone_decoder;

  localparam int CNT_W = 18;

  logic             clk;
  logic             rst_n;
  logic             tone_in;
  logic [5:0]       fullnote;
  logic [2:0]       octave;
  logic [3:0]       note;
  logic             note_valid;
  logic             new_note;
  logic [CNT_W-1:0] half_period;

  int total;
  int bad;
  int valid_drop;
  logic watch_valid;
  logic [5:0] exp_q[$];

  tone_decoder #(
    .CNT_W(CNT_W), .TIMEOUT(150000), .MIN_HALF(2048), .LOCK_COUNT(2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tone_in     (tone_in),
    .fullnote    (fullnote),
    .octave      (octave),
    .note        (note),
    .note_valid  (note_valid),
    .new_note    (new_note),
    .half_period (half_period)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One half-period of exactly h clock cycles, starting with a toggle
  task automatic half(input int h);
    @(negedge clk);
    tone_in = ~tone_in;
    repeat (h - 1) @(negedge clk);
  endtask

  task automatic check_out(input string tag, input logic [5:0] fn, input logic [2:0] oc,
                           input logic [3:0] nt, input logic vl);
    check({tag, "_fullnote"}, 32'(fullnote), 32'(fn));
    check({tag, "_octave"}, 32'(octave), 32'(oc));
    check({tag, "_note"}, 32'(note), 32'(nt));
    check({tag, "_valid"}, 32'(note_valid), 32'(vl));
  endtask

  // Scoreboard: each new_note pulse must match the next expected code
  always @(negedge clk) begin
    if (rst_n) begin
      if (new_note) begin
        check("nn_valid", 32'(note_valid), 32'd1);
        if (exp_q.size() == 0) check("nn_unexpected", 32'(new_note), 32'd0);
        else check("nn_code", 32'(fullnote), 32'(exp_q.pop_front()));
      end
      if (watch_valid && !note_valid) valid_drop++;
    end
  end

  initial begin
    total       = 0;
    bad         = 0;
    valid_drop  = 0;
    watch_valid = 1'b0;
    tone_in     = 1'b0;
    rst_n       = 1'b0;
    repeat (3) @(negedge clk);
    check_out("reset", 6'd0, 3'd0, 4'd0, 1'b0);
    check("reset_new_note", 32'(new_note), 32'd0);
    check("reset_half", 32'(half_period), 32'd0);
    rst_n = 1'b1;

    // Lock on 483*64 = 30912 -> octave 2, note 1, code 25
    exp_q.push_back(6'd25);
    half(30912);
    half(30912);
    check("lock_early_valid", 32'(note_valid), 32'd0);
    half(30912);
    check_out("lock", 6'd25, 3'd2, 4'd1, 1'b1);
    check("lock_half", 32'(half_period), 32'd30912);

    // Change to 362*64 = 23168 -> octave 2, note 6, code 30
    watch_valid = 1'b1;
    exp_q.push_back(6'd30);
    half(23168);
    half(23168);
    check("chg_hold_fullnote", 32'(fullnote), 32'd25);
    half(23168);
    check_out("chg", 6'd30, 3'd2, 4'd6, 1'b1);

    // 100-cycle glitch half is rejected
    half(100);
    half(23168);
    check("glitch_half", 32'(half_period), 32'd23168);
    check_out("glitch", 6'd30, 3'd2, 4'd6, 1'b1);
    half(23168);
    check_out("glitch_after", 6'd30, 3'd2, 4'd6, 1'b1);
    check("valid_held", 32'(valid_drop), 32'd0);
    watch_valid = 1'b0;

    // Silence after a final edge
    @(negedge clk);
    tone_in = ~tone_in;
    repeat (149995) @(negedge clk);
    check("silence_hold", 32'(note_valid), 32'd1);
    begin
      int n;
      n = 0;
      while (note_valid && n < 15) begin
        @(negedge clk);
        n++;
      end
    end
    check_out("silence", 6'd0, 3'd0, 4'd0, 1'b0);
    check("silence_half", 32'(half_period), 32'd23168);

    // Relock on 512*256 = 131072 -> code 0
    exp_q.push_back(6'd0);
    half(131072);
    half(131072);
    check("relock_early_valid", 32'(note_valid), 32'd0);
    half(131072);
    check_out("relock", 6'd0, 3'd0, 4'd0, 1'b1);
    check("relock_half", 32'(half_period), 32'd131072);

    // 271*8 = 2168 -> octave 5, note 11; code 71 wraps to 7 on the 6-bit port
    exp_q.push_back(6'd7);
    half(2168);
    half(2168);
    check("top_hold_fullnote", 32'(fullnote), 32'd0);
    half(2168);
    check_out("top", 6'd7, 3'd5, 4'd11, 1'b1);
    check("top_half", 32'(half_period), 32'd2168);

    // Too short, then too long: both rejected without touching lock
    watch_valid = 1'b1;
    half(2000);
    half(140000);
    check_out("short_rej", 6'd7, 3'd5, 4'd11, 1'b1);
    check("short_rej_half", 32'(half_period), 32'd2168);
    half(2168);
    check_out("long_rej", 6'd7, 3'd5, 4'd11, 1'b1);
    check("long_rej_half", 32'(half_period), 32'd2168);
    check("rej_valid_held", 32'(valid_drop), 32'd0);
    watch_valid = 1'b0;

    // Asynchronous reset between clock edges
    #3;
    rst_n = 1'b0;
    #1;
    check_out("async_rst", 6'd0, 3'd0, 4'd0, 1'b0);
    check("async_rst_half", 32'(half_period), 32'd0);
    check("async_rst_nn", 32'(new_note), 32'd0);
    tone_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(6'd25);
    half(30912);
    check("post_rst_e1_valid", 32'(note_valid), 32'd0);
    half(30912);
    check("post_rst_e2_valid", 32'(note_valid), 32'd0);
    half(30912);
    check_out("post_rst", 6'd25, 3'd2, 4'd1, 1'b1);

    repeat (10) @(negedge clk);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
